// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port unified memory between the instruction-fetch (IF)
// requester and the data-memory (DM) requester of the pipeline. One access is
// in flight at a time. It is granted in IDLE and held on the memory port for
// MEM_LAT cycles (ACCESS). It completes with a one-cycle acknowledge (DONE),
// and then returns to IDLE. Requests are not sampled in DONE, so a requester
// whose req is still high at the end of its ack cycle is not served twice.
//
// Optional feature (compile-time macro):
//   ARB_RR_EN  defined   : a tie goes to the requester that was not granted
//                          last. The first tie after reset goes to DM.
//   ARB_RR_EN  undefined : fixed priority. DM wins every tie, so the older
//                          instruction in the pipeline completes first.
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width
//   MEM_LAT  memory cycles per access, legal range 1..15
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   if_req     fetch request (level, held until if_ack)
//   if_addr    fetch address
//   if_rdata   fetched word, valid while if_ack=1, held between accesses
//   if_ack     one-cycle fetch completion pulse
//   dm_req     data request (level, held until dm_ack)
//   dm_we      data write enable (1 = store, 0 = load)
//   dm_addr    data address
//   dm_wdata   store data
//   dm_rdata   load data, valid while dm_ack=1, held between accesses
//   dm_ack     one-cycle data completion pulse
//   mem_en     memory access enable, high for the whole ACCESS phase
//   mem_we     memory write enable
//   mem_addr   memory address
//   mem_wdata  memory write data
//   mem_rdata  memory read data
//   stall      pipeline freeze request (combinational)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Remaining ACCESS cycles after the grant cycle. For MEM_LAT=1 this is 0,
  // so ACCESS completes on its first edge.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t              state_r;
  logic [3:0]          cnt_r;
  logic                owner_dm_r;
  logic                mem_en_r;
  logic                mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic [DATA_W-1:0]   if_rdata_r;
  logic [DATA_W-1:0]   dm_rdata_r;
  logic                if_ack_r;
  logic                dm_ack_r;
  logic                req_any_s;
  logic                grant_dm_s;

`ifdef ARB_RR_EN
  // Owner of the most recent grant; 0 = IF, 1 = DM.
  logic                last_dm_r;
`endif

  assign req_any_s = if_req | dm_req;

  // Grant selection: a lone requester always wins; a tie is resolved by the
  // configured arbitration policy.
  always_comb begin
    grant_dm_s = 1'b0;
    if (dm_req && !if_req) begin
      grant_dm_s = 1'b1;
    end else if (dm_req && if_req) begin
`ifdef ARB_RR_EN
      grant_dm_s = ~last_dm_r;
`else
      grant_dm_s = 1'b1;
`endif
    end else begin
      grant_dm_s = 1'b0;
    end
  end

`ifdef ARB_RR_EN
  // Round-robin history: remember who was granted at every grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_dm_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && req_any_s) begin
      last_dm_r <= grant_dm_s;
    end else begin
      last_dm_r <= last_dm_r;
    end
  end
`endif

  // Access sequencer: grant in IDLE, drive the memory for MEM_LAT cycles,
  // capture the read data and pulse the owner's ack in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      owner_dm_r  <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      if_rdata_r  <= {DATA_W{1'b0}};
      dm_rdata_r  <= {DATA_W{1'b0}};
      if_ack_r    <= 1'b0;
      dm_ack_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_any_s) begin
            state_r    <= ST_ACCESS;
            cnt_r      <= CNT_INIT;
            owner_dm_r <= grant_dm_s;
            mem_en_r   <= 1'b1;
            if (grant_dm_s) begin
              mem_we_r    <= dm_we;
              mem_addr_r  <= dm_addr;
              mem_wdata_r <= dm_wdata;
            end else begin
              // Fetches never write.
              mem_we_r    <= 1'b0;
              mem_addr_r  <= if_addr;
              mem_wdata_r <= {DATA_W{1'b0}};
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_ACCESS: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            state_r  <= ST_DONE;
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
            if (owner_dm_r) begin
              dm_ack_r <= 1'b1;
              // A store returns no data; the load register keeps its value.
              if (!mem_we_r) begin
                dm_rdata_r <= mem_rdata;
              end else begin
                dm_rdata_r <= dm_rdata_r;
              end
            end else begin
              if_ack_r   <= 1'b1;
              if_rdata_r <= mem_rdata;
            end
          end
        end

        ST_DONE: begin
          // Requests are deliberately ignored here.
          if_ack_r <= 1'b0;
          dm_ack_r <= 1'b0;
          state_r  <= ST_IDLE;
        end

        default: begin
          state_r  <= ST_IDLE;
          cnt_r    <= 4'd0;
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
          if_ack_r <= 1'b0;
          dm_ack_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign if_rdata  = if_rdata_r;
  assign dm_rdata  = dm_rdata_r;
  assign if_ack    = if_ack_r;
  assign dm_ack    = dm_ack_r;

  // Freeze the pipeline while a requester waits. It is released in the ack
  // cycle so the stage can advance on the edge that ends the ack.
  assign stall = (if_req & ~if_ack_r) | (dm_req & ~dm_ack_r);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        if_req, if_ack, dm_req, dm_we, dm_ack, mem_en, mem_we, stall;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // Second instance with MEM_LAT=1
  logic        u1_if_req, u1_if_ack, u1_dm_req, u1_dm_we, u1_dm_ack;
  logic        u1_mem_en, u1_mem_we, u1_stall;
  logic [31:0] u1_if_addr, u1_if_rdata, u1_dm_addr, u1_dm_wdata, u1_dm_rdata;
  logic [31:0] u1_mem_addr, u1_mem_wdata, u1_mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(u1_if_req), .if_addr(u1_if_addr), .if_rdata(u1_if_rdata), .if_ack(u1_if_ack),
    .dm_req(u1_dm_req), .dm_we(u1_dm_we), .dm_addr(u1_dm_addr), .dm_wdata(u1_dm_wdata),
    .dm_rdata(u1_dm_rdata), .dm_ack(u1_dm_ack),
    .mem_en(u1_mem_en), .mem_we(u1_mem_we), .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata),
    .mem_rdata(u1_mem_rdata), .stall(u1_stall)
  );

  // Memory stub: unwritten words read back a fixed address pattern
  function automatic logic [31:0] init_pat(input logic [31:0] a);
    return 32'h2002_0001 + a;
  endfunction

  bit [31:0] stub_mem [256];
  bit        stub_vld [256];
  assign mem_rdata = stub_vld[mem_addr[9:2]] ? stub_mem[mem_addr[9:2]] : init_pat(mem_addr);
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      stub_mem[mem_addr[9:2]] <= mem_wdata;
      stub_vld[mem_addr[9:2]] <= 1'b1;
    end
  end
  assign u1_mem_rdata = (u1_mem_addr == 32'h0000_0008) ? 32'h1234_5678 : 32'h0000_0000;

  // Grant monitor: records the cycle and address of each mem_en rise
  int          cyc = 0;
  logic        en_q = 1'b0;
  int          g_cyc[$];
  logic [31:0] g_addr[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    en_q <= mem_en;
    if (mem_en && !en_q) begin
      g_cyc.push_back(cyc);
      g_addr.push_back(mem_addr);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ir;  logic [31:0] ia;
    logic        dr;  logic dw; logic [31:0] da; logic [31:0] dd;
    logic        e_en; logic e_we; logic [31:0] e_addr;
    logic        e_ia; logic e_da; logic e_st;
    logic [31:0] e_ird; logic [31:0] e_drd;
  } vec_t;

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dw,
                              logic [31:0] da, logic [31:0] dd, logic en, logic we,
                              logic [31:0] ea, logic eia, logic eda, logic st,
                              logic [31:0] eird, logic [31:0] edrd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.e_en = en; v.e_we = we; v.e_addr = ea; v.e_ia = eia; v.e_da = eda;
    v.e_st = st; v.e_ird = eird; v.e_drd = edrd;
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h0000_0100 + 32'($urandom_range(0, 63)) * 32'd4;
  endfunction

  // Reference model state (random phase)
  logic [31:0] ref_mem [int];
  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_pat(a);
  endfunction

  initial begin : main
    vec_t        vecs [16];
    logic [31:0] FI, BE, Z;
    int          base;
    bit          done;
    // model
    int          free_at, g;
    bit          busy, own_dm, own_we, m_last_dm, ack_if, ack_dm, if_ow, dm_ow;
    bit          e_en, e_ia, e_da;
    logic [31:0] own_addr, own_wdata, exp_ird, exp_drd;

    FI = 32'h2002_0005; BE = 32'hDEAD_BEEF; Z = 32'h0;
    //          ir   ia      dr   dw   da      dd  en   we   addr    ia   da   st   ird            drd
    vecs[0]  = mk(1, 32'h4, 0, 0, Z,     Z,  1, 0, 32'h4,  0, 0, 1, Z,             Z);
    vecs[1]  = mk(1, 32'h4, 0, 0, Z,     Z,  1, 0, 32'h4,  0, 0, 1, Z,             Z);
    vecs[2]  = mk(1, 32'h4, 0, 0, Z,     Z,  0, 0, Z,      1, 0, 0, FI,            Z);
    vecs[3]  = mk(0, 32'h4, 0, 0, Z,     Z,  0, 0, Z,      0, 0, 0, FI,            Z);
    vecs[4]  = mk(0, Z,     1, 1, 32'h40, BE, 1, 1, 32'h40, 0, 0, 1, FI,            Z);
    vecs[5]  = mk(0, Z,     1, 1, 32'h40, BE, 1, 1, 32'h40, 0, 0, 1, FI,            Z);
    vecs[6]  = mk(0, Z,     1, 1, 32'h40, BE, 0, 0, Z,      0, 1, 0, FI,            Z);
    vecs[7]  = mk(0, Z,     0, 0, Z,     Z,  0, 0, Z,      0, 0, 0, FI,            Z);
    vecs[8]  = mk(1, 32'h8, 0, 0, Z,     Z,  1, 0, 32'h8,  0, 0, 1, FI,            Z);
    vecs[9]  = mk(1, 32'h8, 0, 0, Z,     Z,  1, 0, 32'h8,  0, 0, 1, FI,            Z);
    vecs[10] = mk(1, 32'h8, 0, 0, Z,     Z,  0, 0, Z,      1, 0, 0, 32'h2002_0009, Z);
    vecs[11] = mk(1, 32'h8, 0, 0, Z,     Z,  0, 0, Z,      0, 0, 1, 32'h2002_0009, Z);
    vecs[12] = mk(1, 32'h8, 0, 0, Z,     Z,  1, 0, 32'h8,  0, 0, 1, 32'h2002_0009, Z);
    vecs[13] = mk(1, 32'h8, 0, 0, Z,     Z,  1, 0, 32'h8,  0, 0, 1, 32'h2002_0009, Z);
    vecs[14] = mk(1, 32'h8, 0, 0, Z,     Z,  0, 0, Z,      1, 0, 0, 32'h2002_0009, Z);
    vecs[15] = mk(0, 32'h8, 0, 0, Z,     Z,  0, 0, Z,      0, 0, 0, 32'h2002_0009, Z);

    reset = 1'b0;
    if_req = 1'b0; if_addr = Z; dm_req = 1'b0; dm_we = 1'b0; dm_addr = Z; dm_wdata = Z;
    u1_if_req = 1'b0; u1_if_addr = Z; u1_dm_req = 1'b0; u1_dm_we = 1'b0;
    u1_dm_addr = Z; u1_dm_wdata = Z;

    // ---- reset values
    #12;
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, Z);
    chk("rst_mem_wdata", mem_wdata, Z);
    chk("rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
    chk("rst_if_rdata", if_rdata, Z);
    chk("rst_dm_rdata", dm_rdata, Z);
    @(negedge clk) reset = 1'b1;

    // ---- table: single fetch, data write, held request after ack
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if_req = vecs[i].ir; if_addr = vecs[i].ia;
      dm_req = vecs[i].dr; dm_we = vecs[i].dw; dm_addr = vecs[i].da; dm_wdata = vecs[i].dd;
      @(posedge clk); #1;
      chk($sformatf("v%0d_mem_en", i), {31'd0, mem_en}, {31'd0, vecs[i].e_en});
      chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_we});
      if (vecs[i].e_en) chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      if (vecs[i].e_we) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].dd);
      chk($sformatf("v%0d_if_ack", i), {31'd0, if_ack}, {31'd0, vecs[i].e_ia});
      chk($sformatf("v%0d_dm_ack", i), {31'd0, dm_ack}, {31'd0, vecs[i].e_da});
      chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].e_st});
      chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_ird);
      chk($sformatf("v%0d_dm_rdata", i), dm_rdata, vecs[i].e_drd);
    end

    // ---- tie, each drops after its ack: DM first, IF 4 cycles later
    base = g_cyc.size();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      if (dm_ack) begin
        chk("tie_dm_rdata", dm_rdata, BE);
        dm_req = 1'b0;
      end
      if (if_ack) begin
        chk("tie_if_rdata", if_rdata, 32'h2002_0011);
        if_req = 1'b0;
        done = 1'b1;
      end
    end
    chk("tie_completed", {31'd0, done}, 32'd1);
    chk("tie_grants", g_cyc.size() - base, 32'd2);
    if (g_cyc.size() - base == 2) begin
      chk("tie_first_dm", g_addr[base], 32'h40);
      chk("tie_second_if", g_addr[base+1], 32'h10);
      chk("tie_gap", g_cyc[base+1] - g_cyc[base], LAT + 2);
    end
    repeat (2) @(posedge clk);

    // ---- repeated ties, both held
    base = g_cyc.size();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
    for (int i = 0; i < 30 && (g_cyc.size() - base) < 4; i++) begin
      @(posedge clk); #1;
    end
    if_req = 1'b0; dm_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rr_grants", g_cyc.size() - base, 32'd4);
    if (g_cyc.size() - base == 4) begin
      for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
        chk($sformatf("rr_owner%0d", i), g_addr[base+i], (i % 2 == 0) ? 32'h44 : 32'h10);
`else
        chk($sformatf("rr_owner%0d", i), g_addr[base+i], 32'h44);
`endif
        if (i > 0) chk($sformatf("rr_gap%0d", i), g_cyc[base+i] - g_cyc[base+i-1], LAT + 2);
      end
    end

    // ---- reset mid-ACCESS
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h48;
    @(posedge clk); #1;
    chk("mid_grant_en", {31'd0, mem_en}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_en_drop", {31'd0, mem_en}, 32'd0);
    chk("mid_addr", mem_addr, Z);
    chk("mid_we", {31'd0, mem_we}, 32'd0);
    chk("mid_rdata", if_rdata | dm_rdata, Z);
    chk("mid_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    chk("mid_no_ack", {30'd0, if_ack, dm_ack}, 32'd0);
    chk("mid_held_en", {31'd0, mem_en}, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("post_grant_en", {31'd0, mem_en}, 32'd1);
    chk("post_grant_addr", mem_addr, 32'h48);
    @(posedge clk); #1;
    chk("post_no_early_ack", {31'd0, dm_ack}, 32'd0);
    @(posedge clk); #1;
    chk("post_ack", {31'd0, dm_ack}, 32'd1);
    chk("post_rdata", dm_rdata, 32'h2002_0049);
    @(negedge clk) dm_req = 1'b0;
    @(posedge clk); #1;
    chk("post_ack_pulse", {31'd0, dm_ack}, 32'd0);

    // ---- randomized traffic against a schedule-based model
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    free_at = 0; g = 0; busy = 1'b0; own_dm = 1'b0; own_we = 1'b0; m_last_dm = 1'b0;
    own_addr = Z; own_wdata = Z; exp_ird = Z; exp_drd = Z;
    ack_if = 1'b0; ack_dm = 1'b0; if_ow = 1'b0; dm_ow = 1'b0;
    if_req = 1'b0; dm_req = 1'b0;
    for (int t = 0; t < 600; t++) begin
      if (t != 0) @(negedge clk);
      // IF agent
      if (if_ow && ack_if) if_ow = 1'b0;
      if (!if_ow) begin
        if ($urandom_range(0, 2) == 0) begin
          if_ow = 1'b1; if_addr = rand_addr(); if_req = 1'b1;
        end else begin
          if_req = 1'b0;
        end
      end else if (busy && !own_dm && $urandom_range(0, 5) == 0) begin
        if_req = 1'b0;
      end
      // DM agent
      if (dm_ow && ack_dm) dm_ow = 1'b0;
      if (!dm_ow) begin
        if ($urandom_range(0, 2) == 0) begin
          dm_ow = 1'b1; dm_addr = rand_addr(); dm_we = 1'($urandom_range(0, 1));
          dm_wdata = $urandom(); dm_req = 1'b1;
        end else begin
          dm_req = 1'b0;
        end
      end else if (busy && own_dm && $urandom_range(0, 5) == 0) begin
        dm_req = 1'b0;
      end
      // grant decision for edge t
      if (t >= free_at && (if_req || dm_req)) begin
`ifdef ARB_RR_EN
        own_dm = dm_req && (!if_req || !m_last_dm);
`else
        own_dm = dm_req;
`endif
        m_last_dm = own_dm;
        own_we    = own_dm && dm_we;
        own_addr  = own_dm ? dm_addr : if_addr;
        own_wdata = dm_wdata;
        if (own_we) ref_mem[int'(own_addr)] = own_wdata;
        g = t; busy = 1'b1; free_at = t + LAT + 2;
      end
      @(posedge clk); #1;
      e_en = busy && t >= g && t <= g + LAT - 1;
      e_ia = busy && t == g + LAT && !own_dm;
      e_da = busy && t == g + LAT && own_dm;
      if (e_ia) exp_ird = ref_read(own_addr);
      if (e_da && !own_we) exp_drd = ref_read(own_addr);
      chk("rnd_mem_en", {31'd0, mem_en}, {31'd0, e_en});
      if (e_en) begin
        chk("rnd_mem_we", {31'd0, mem_we}, {31'd0, own_we});
        chk("rnd_mem_addr", mem_addr, own_addr);
        if (own_we) chk("rnd_mem_wdata", mem_wdata, own_wdata);
      end
      chk("rnd_if_ack", {31'd0, if_ack}, {31'd0, e_ia});
      chk("rnd_dm_ack", {31'd0, dm_ack}, {31'd0, e_da});
      chk("rnd_if_rdata", if_rdata, exp_ird);
      chk("rnd_dm_rdata", dm_rdata, exp_drd);
      chk("rnd_stall", {31'd0, stall}, {31'd0, (if_req & ~e_ia) | (dm_req & ~e_da)});
      ack_if = e_ia; ack_dm = e_da;
      if (busy && t == g + LAT) busy = 1'b0;
    end
    @(negedge clk);
    if_req = 1'b0; dm_req = 1'b0;

    // ---- MEM_LAT=1 read
    @(negedge clk);
    u1_dm_req = 1'b1; u1_dm_we = 1'b0; u1_dm_addr = 32'h8;
    @(posedge clk); #1;
    chk("l1_grant_en", {31'd0, u1_mem_en}, 32'd1);
    chk("l1_grant_addr", u1_mem_addr, 32'h8);
    chk("l1_no_ack_yet", {31'd0, u1_dm_ack}, 32'd0);
    chk("l1_stall", {31'd0, u1_stall}, 32'd1);
    @(posedge clk); #1;
    chk("l1_en_done", {31'd0, u1_mem_en}, 32'd0);
    chk("l1_ack", {31'd0, u1_dm_ack}, 32'd1);
    chk("l1_rdata", u1_dm_rdata, 32'h1234_5678);
    @(negedge clk) u1_dm_req = 1'b0;
    @(posedge clk); #1;
    chk("l1_ack_pulse", {31'd0, u1_dm_ack}, 32'd0);
    chk("l1_rdata_hold", u1_dm_rdata, 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
